fpu_addsub_issue: RTL and testbench
===================================

// Module: fpu_addsub_issue
// PURPOSE
//  Initiator and writeback side of the 5-stage add/sub FPU pipeline.
//  - Accepts add/sub requests (operands plus destination register tag) from the FP dispatch stage.
//  - Drives the FPU start/operand interface and matches each returning result to its tag.
//  - Buffers results for the FP register-file write port.
//  - The FPU pipeline cannot stall, so a credit scheme guarantees every in-flight result has a slot.
// PARAMETERS
//  FPU_LAT    5   cycles from fpu_start to fpu_ready; informational only, no logic depends on it
//  RES_DEPTH  8   result FIFO entries = max(in-flight + buffered); power of 2, >=2
//  TAG_W      5   destination register tag width
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      asynchronous reset, active low
//  req_valid     in   1      request valid
//  req_ready     out  1      request accepted when valid & ready
//  req_sub       in   1      0: add, 1: subtract
//  req_a         in   32     IEEE-754 single operand a
//  req_b         in   32     IEEE-754 single operand b
//  req_rd        in   TAG_W  destination register tag
//  fpu_start     out  1      to FPU start
//  fpu_add_sub   out  1      to FPU add_sub
//  fpu_a         out  32     to FPU a
//  fpu_b         out  32     to FPU b
//  fpu_ready     in   1      FPU result valid, one cycle per op
//  fpu_result    in   32     FPU result
//  wb_valid      out  1      writeback entry available
//  wb_ready      in   1      register file accepts entry
//  wb_rd         out  TAG_W  writeback tag
//  wb_data       out  32     writeback data
//  busy          out  1      any op in flight or buffered
//  err_spurious  out  1      sticky: fpu_ready seen with tag FIFO empty
// BEHAVIOUR
//  Reset (rst_n=0, async):
//  - inflight=0, both FIFOs empty, err_spurious=0.
//  - Outputs: req_ready=1, wb_valid=0, busy=0, fpu_start=0.
//  - FPU is reset by the same net, inverted at the top level.
//  - Ops in flight when reset asserts are discarded.
//  Credit and issue:
//  - req_ready = (inflight + res_count) < RES_DEPTH. Computed from registers only; no path from req_valid.
//  - issue = req_valid & req_ready.
//  - fpu_start = issue; fpu_add_sub/a/b = req_sub/a/b, combinational pass-through (FPU registers them).
//  - On issue, req_rd is pushed into the tag FIFO (depth RES_DEPTH).
//  - Back-to-back issue every cycle is legal while credits remain.
//  Inflight counter ($clog2(RES_DEPTH)+1 bits):
//  - +1 on issue, -1 on fpu_ready.
//  - Both in the same cycle: no change.
//  Completion, on fpu_ready:
//  - Pop the tag FIFO head.
//  - Push {tag, fpu_result} into the result FIFO in the same cycle.
//  - Results return in issue order, so no reordering is done.
//  - The credit rule guarantees no overflow. The FIFO asserts overflow in simulation only.
//  Writeback:
//  - wb_valid = result FIFO not empty; wb_rd/wb_data = head entry, registered FIFO output.
//  - Pop on wb_valid & wb_ready. wb_rd/wb_data are held stable while wb_valid & !wb_ready.
//  - Push and pop in the same cycle is legal, including when the FIFO is full (pop frees the slot first).
//  - Latency: issue at cycle T gives fpu_ready at T+FPU_LAT and wb_valid at T+FPU_LAT+1 when the FIFO was empty.
//  Error:
//  - fpu_ready with tag FIFO empty: set err_spurious (sticky until reset); no push, no pop.
//  - inflight does not underflow (saturates at 0).
//  busy = (inflight != 0) | wb_valid.
//  Pointers are log2(RES_DEPTH)+1 bits and wrap modulo 2*RES_DEPTH; full = MSB differs and rest equal.
// STRUCTURE
//  - fpu_pkg holds the FPU_OP_ADD=0 / FPU_OP_SUB=1 constants, FPU_ADDSUB_LAT=5, and the IEEE single field widths.
//  - Sub-module fpu_sync_fifo #(WIDTH, DEPTH), instantiated twice:
//    - tag FIFO, WIDTH=TAG_W;
//    - result FIFO, WIDTH=TAG_W+32.
//  - The top level holds the credit counter, issue logic and the error flag.
// TESTING
//  1. Single op: a=0x3F800000, b=0x40000000, add, rd=3 -> wb_valid at T+6, wb_rd=3, wb_data=0x40400000.
//  2. Subtract: a=0x40400000, b=0x3F800000, sub, rd=7 -> wb_data=0x40000000, wb_rd=7.
//  3. Full credit: wb_ready=0, issue 9 back-to-back -> 8 accepted, req_ready=0 from cycle 8 on.
//     Then wb_ready=1 -> 8 results drain in order, req_ready reasserts.
//  4. Streaming: wb_ready=1, 20 consecutive ops with rd=0..19 mod 32 -> one result per cycle, tags in order, req_ready never drops.
//  5. Backpressure: toggle wb_ready every other cycle -> wb_rd/wb_data stable while stalled; no loss or duplication.
//  6. Reset mid-flight: 3 ops issued, rst_n low 2 cycles -> wb_valid=0, busy=0, req_ready=1; next op returns correctly.
//  7. Spurious: force fpu_ready=1 while idle -> err_spurious=1 and stays 1; wb_valid stays 0.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared constants for the add/sub FPU issue/writeback slice:
//                operation encodings, pipeline latency, IEEE single widths.
//  Revision    : 1.0  initial release
// ============================================================================
package fpu_pkg;

  // FPU add_sub encodings
  localparam logic FPU_OP_ADD = 1'b0;
  localparam logic FPU_OP_SUB = 1'b1;

  // Cycles from fpu_start to fpu_ready of the add/sub pipeline
  localparam int FPU_ADDSUB_LAT = 5;

  // IEEE-754 single precision field widths
  localparam int SP_EXP_W = 8;
  localparam int SP_MAN_W = 23;
  localparam int SP_W     = 1 + SP_EXP_W + SP_MAN_W;

endpackage
`default_nettype wire

// File: rtl/fpu_addsub_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_addsub_issue_if
//  Description : Request, FPU and writeback signals of the add/sub issue
//                block. slave = issue block view, master = environment
//                (dispatch stage, FPU pipeline, register file).
//  Revision    : 1.0  initial release
// ============================================================================
interface fpu_addsub_issue_if #(
  parameter int TAG_W = 5
) ();

  // Dispatch request
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_sub;
  logic [fpu_pkg::SP_W-1:0]   req_a;
  logic [fpu_pkg::SP_W-1:0]   req_b;
  logic [TAG_W-1:0]           req_rd;

  // FPU start / result
  logic                       fpu_start;
  logic                       fpu_add_sub;
  logic [fpu_pkg::SP_W-1:0]   fpu_a;
  logic [fpu_pkg::SP_W-1:0]   fpu_b;
  logic                       fpu_ready;
  logic [fpu_pkg::SP_W-1:0]   fpu_result;

  // Register-file writeback
  logic                       wb_valid;
  logic                       wb_ready;
  logic [TAG_W-1:0]           wb_rd;
  logic [fpu_pkg::SP_W-1:0]   wb_data;

  // Status
  logic                       busy;
  logic                       err_spurious;

  modport slave (
    input  req_valid, req_sub, req_a, req_b, req_rd,
    output req_ready,
    output fpu_start, fpu_add_sub, fpu_a, fpu_b,
    input  fpu_ready, fpu_result,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready,
    output busy, err_spurious
  );

  modport master (
    output req_valid, req_sub, req_a, req_b, req_rd,
    input  req_ready,
    input  fpu_start, fpu_add_sub, fpu_a, fpu_b,
    output fpu_ready, fpu_result,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready,
    input  busy, err_spurious
  );

endinterface
`default_nettype wire

// File: rtl/fpu_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_sync_fifo
//  Description : Synchronous FIFO with extra-MSB pointers. Head entry is read
//                straight from the storage registers. A pop in the same
//                cycle frees a slot for a push even when full.
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_data,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;

  // Pointer update; both wrap modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Upstream credit logic must never push into a full FIFO without a pop
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && w_full && !i_pop));

endmodule
`default_nettype wire

// File: rtl/fpu_addsub_issue.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_addsub_issue
//  Description : Issue and writeback side of the 5-stage add/sub FPU. Drives
//                the FPU, tracks destination tags in issue order and buffers
//                results for the register-file write port. Credits ensure
//                every in-flight result already owns a result FIFO slot.
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_addsub_issue
  import fpu_pkg::*;
#(
  parameter int FPU_LAT   = FPU_ADDSUB_LAT,
  parameter int RES_DEPTH = 8,
  parameter int TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpu_addsub_issue_if.slave    bus
);

  localparam int CW = $clog2(RES_DEPTH) + 1;
  localparam int RW = TAG_W + SP_W;

  // Elaboration-time parameter sanity
  if (FPU_LAT < 1) begin : g_bad_lat
    $error("FPU_LAT must be at least 1");
  end
  if (RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RES_DEPTH must be a power of 2 and >= 2");
  end

  logic [CW-1:0]    r_inflight;
  logic             r_err;
  logic [CW-1:0]    w_tag_count;
  logic [CW-1:0]    w_res_count;
  logic [CW:0]      w_credit_used;
  logic [TAG_W-1:0] w_tag_head;
  logic [RW-1:0]    w_res_head;
  logic             w_req_ready;
  logic             w_issue;
  logic             w_tag_empty;
  logic             w_complete;
  logic             w_spurious;
  logic             w_wb_valid;
  logic             w_wb_pop;

  // Credits depend on registered counts only, never on req_valid
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_res_count};
  assign w_req_ready   = w_credit_used < (CW+1)'(RES_DEPTH);
  assign w_issue       = bus.req_valid & w_req_ready;

  assign w_tag_empty = (w_tag_count == '0);
  assign w_complete  = bus.fpu_ready & ~w_tag_empty;
  assign w_spurious  = bus.fpu_ready & w_tag_empty;
  assign w_wb_valid  = (w_res_count != '0);
  assign w_wb_pop    = w_wb_valid & bus.wb_ready;

  assign bus.req_ready    = w_req_ready;
  assign bus.fpu_start    = w_issue;
  assign bus.fpu_add_sub  = bus.req_sub ? FPU_OP_SUB : FPU_OP_ADD;
  assign bus.fpu_a        = bus.req_a;
  assign bus.fpu_b        = bus.req_b;
  assign bus.wb_valid     = w_wb_valid;
  assign bus.wb_rd        = w_res_head[RW-1 -: TAG_W];
  assign bus.wb_data      = w_res_head[SP_W-1:0];
  assign bus.busy         = (r_inflight != '0) | w_wb_valid;
  assign bus.err_spurious = r_err;

  // In-flight count: up on issue, down on fpu_ready, saturating at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else if (w_issue && !bus.fpu_ready) begin
      r_inflight <= r_inflight + CW'(1);
    end else if (!w_issue && bus.fpu_ready && (r_inflight != '0)) begin
      r_inflight <= r_inflight - CW'(1);
    end
  end

  // Sticky flag for a result arriving with no outstanding tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_err <= 1'b0;
    else if (w_spurious) r_err <= 1'b1;
  end

  // Destination tags in issue order; results return in the same order
  fpu_sync_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (RES_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_issue),
    .i_data  (bus.req_rd),
    .i_pop   (w_complete),
    .o_data  (w_tag_head),
    .o_count (w_tag_count)
  );

  // Completed {tag, result} entries awaiting register-file writeback
  fpu_sync_fifo #(
    .WIDTH (RW),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_complete),
    .i_data  ({w_tag_head, bus.fpu_result}),
    .i_pop   (w_wb_pop),
    .o_data  (w_res_head),
    .o_count (w_res_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_addsub_issue
//  Description : Bench for fpu_addsub_issue with a behavioural 5-cycle FPU
//                and an integer-valued IEEE single reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fpu_addsub_issue;

  logic clk = 1'b0;
  logic rst_n;
  logic force_ready;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  fpu_addsub_issue_if #(.TAG_W(5)) bus ();

  fpu_addsub_issue #(
    .FPU_LAT   (5),
    .RES_DEPTH (8),
    .TAG_W     (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  req_t        iss_q[$];
  logic [36:0] obs_q[$];
  int          obs_t[$];

  // ---- reference model: operands are small integers held as IEEE singles
  function automatic int f2i(input logic [31:0] f);
    int e;
    e = int'(f[30:23]) - 127;
    if (f[30:0] == 31'd0 || e < 0 || e > 23) return 0;
    return (f[31] ? -1 : 1) * int'((32'h800000 | {9'd0, f[22:0]}) >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int m, p;
    logic [31:0] shifted;
    if (v == 0) return 32'd0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if ((m >> i) != 0) p = i;
    shifted = 32'(m) << (23 - p);
    return {(v < 0), 8'(127 + p), shifted[22:0]};
  endfunction

  function automatic logic [31:0] fp_ref(input logic sub, input logic [31:0] a, input logic [31:0] b);
    return sub ? i2f(f2i(a) - f2i(b)) : i2f(f2i(a) + f2i(b));
  endfunction

  // ---- behavioural FPU: fixed 5-cycle pipeline, reset with the DUT
  logic [4:0]  stg_v;
  logic [31:0] stg_r [5];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_v <= '0;
    end else begin
      stg_v    <= {stg_v[3:0], bus.fpu_start};
      stg_r[0] <= fp_ref(bus.fpu_add_sub, bus.fpu_a, bus.fpu_b);
      for (int i = 1; i < 5; i++) stg_r[i] <= stg_r[i-1];
    end
  end
  assign bus.fpu_ready  = stg_v[4] | force_ready;
  assign bus.fpu_result = stg_r[4];

  // ---- cycle counter and handshake monitor
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_valid && bus.req_ready)
        iss_q.push_back('{rd: bus.req_rd, sub: bus.req_sub, a: bus.req_a, b: bus.req_b});
      if (bus.wb_valid && bus.wb_ready) begin
        obs_q.push_back({bus.wb_rd, bus.wb_data});
        obs_t.push_back(cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---- stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sub, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bus.req_valid = v;
    bus.req_sub   = sub;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_rd    = rd;
  endtask

  function automatic logic [31:0] rnd_op();
    return i2f(int'($urandom_range(1, 1000)));
  endfunction

  task automatic clear_q();
    iss_q.delete();
    obs_q.delete();
    obs_t.delete();
  endtask

  // ---- scenarios
  task automatic test_reset();
    rst_n       = 1'b0;
    force_ready = 1'b0;
    bus.wb_ready = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_chk++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.fpu_start !== 1'b0) begin n_fail++; $display("FAIL reset_fpu_start: got %b want 0", bus.fpu_start); end
    n_chk++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_spurious); end
  endtask

  task automatic test_single();
    clear_q();
    bus.wb_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h3F800000, 32'h40000000, 5'd3);
    #1;
    n_chk++; if (bus.fpu_start !== 1'b1 || bus.fpu_a !== 32'h3F800000 || bus.fpu_b !== 32'h40000000 || bus.fpu_add_sub !== 1'b0) begin
      n_fail++; $display("FAIL single_fpu_drive: got start=%b op=%b a=%h b=%h want 1 0 3f800000 40000000",
                         bus.fpu_start, bus.fpu_add_sub, bus.fpu_a, bus.fpu_b);
    end
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    repeat (4) step();
    n_chk++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: wb_valid got %b want 0 at T+5", bus.wb_valid); end
    step();
    n_chk++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: wb_valid got %b want 1 at T+6", bus.wb_valid); end
    n_chk++; if (bus.wb_rd !== 5'd3 || bus.wb_data !== 32'h40400000) begin
      n_fail++; $display("FAIL single_data: got rd=%0d data=%h want rd=3 data=40400000", bus.wb_rd, bus.wb_data);
    end
    step();
    n_chk++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got wb_valid=%b busy=%b want 0 0", bus.wb_valid, bus.busy);
    end
  endtask

  task automatic test_sub();
    int k;
    clear_q();
    bus.wb_ready = 1'b1;
    drive(1'b1, 1'b1, 32'h40400000, 32'h3F800000, 5'd7);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    k = 0;
    while (bus.wb_valid !== 1'b1 && k < 20) begin step(); k++; end
    n_chk++; if (bus.wb_rd !== 5'd7 || bus.wb_data !== 32'h40000000) begin
      n_fail++; $display("FAIL sub_data: got valid=%b rd=%0d data=%h want 1 7 40000000", bus.wb_valid, bus.wb_rd, bus.wb_data);
    end
    step();
  endtask

  task automatic test_full_credit();
    int acc, bad, k;
    logic [36:0] exp;
    clear_q();
    bus.wb_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 5'($urandom));
      if (bus.req_ready === 1'b1) acc++;
      if (i == 8) begin
        n_chk++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ninth: req_ready got %b want 0", bus.req_ready); end
      end
      step();
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req_ready !== 1'b0) bad++;
      step();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL full_hold: req_ready high in %0d cycles want 0", bad); end
    n_chk++; if (acc != 8) begin n_fail++; $display("FAIL full_accepted: got %0d want 8", acc); end
    n_chk++; if (bus.wb_valid !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL full_buffered: got wb_valid=%b busy=%b want 1 1", bus.wb_valid, bus.busy);
    end
    bus.wb_ready = 1'b1;
    k = 0;
    while (obs_q.size() < 8 && k < 40) begin step(); k++; end
    step();
    n_chk++; if (obs_q.size() != 8 || iss_q.size() != 8) begin
      n_fail++; $display("FAIL full_count: got obs=%0d iss=%0d want 8 8", obs_q.size(), iss_q.size());
    end
    for (int i = 0; i < 8 && i < obs_q.size() && i < iss_q.size(); i++) begin
      exp = {iss_q[i].rd, fp_ref(iss_q[i].sub, iss_q[i].a, iss_q[i].b)};
      n_chk++; if (obs_q[i] !== exp) begin n_fail++; $display("FAIL full_order[%0d]: got %h want %h", i, obs_q[i], exp); end
    end
    n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL full_reassert: req_ready got %b want 1", bus.req_ready); end
  endtask

  task automatic test_streaming();
    int drops, k, gaps;
    logic [36:0] exp;
    clear_q();
    bus.wb_ready = 1'b1;
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 5'(i % 32));
      if (bus.req_ready !== 1'b1) drops++;
      step();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    n_chk++; if (drops != 0) begin n_fail++; $display("FAIL stream_ready: req_ready low %0d cycles want 0", drops); end
    k = 0;
    while (obs_q.size() < 20 && k < 40) begin step(); k++; end
    n_chk++; if (obs_q.size() != 20) begin n_fail++; $display("FAIL stream_count: got %0d want 20", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < iss_q.size(); i++) begin
      exp = {5'(i % 32), fp_ref(iss_q[i].sub, iss_q[i].a, iss_q[i].b)};
      n_chk++; if (obs_q[i] !== exp) begin n_fail++; $display("FAIL stream_entry[%0d]: got %h want %h", i, obs_q[i], exp); end
    end
    gaps = 0;
    for (int i = 1; i < obs_t.size(); i++) if (obs_t[i] - obs_t[i-1] != 1) gaps++;
    n_chk++; if (gaps != 0) begin n_fail++; $display("FAIL stream_rate: got %0d gaps want 0", gaps); end
  endtask

  task automatic test_back_to_back_backpressure();
    int sent, k;
    logic stalled;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic [36:0] exp;
    clear_q();
    sent = 0;
    stalled = 1'b0;
    s_rd = '0;
    s_data = '0;
    k = 0;
    while ((sent < 12 || obs_q.size() < 12) && k < 200) begin
      if (stalled) begin
        n_chk++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== s_rd || bus.wb_data !== s_data) begin
          n_fail++; $display("FAIL bp_stable: got v=%b rd=%0d data=%h want 1 %0d %h", bus.wb_valid, bus.wb_rd, bus.wb_data, s_rd, s_data);
        end
      end
      if (sent < 12 && bus.req_ready === 1'b1 && $urandom_range(0, 3) != 0) begin
        drive(1'b1, 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 5'($urandom));
        sent++;
      end else begin
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      end
      bus.wb_ready = k[0];
      stalled = bus.wb_valid & ~bus.wb_ready;
      s_rd    = bus.wb_rd;
      s_data  = bus.wb_data;
      step();
      k++;
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    bus.wb_ready = 1'b1;
    repeat (3) step();
    n_chk++; if (obs_q.size() != 12 || iss_q.size() != 12) begin
      n_fail++; $display("FAIL bp_count: got obs=%0d iss=%0d want 12 12", obs_q.size(), iss_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < iss_q.size(); i++) begin
      exp = {iss_q[i].rd, fp_ref(iss_q[i].sub, iss_q[i].a, iss_q[i].b)};
      n_chk++; if (obs_q[i] !== exp) begin n_fail++; $display("FAIL bp_entry[%0d]: got %h want %h", i, obs_q[i], exp); end
    end
  endtask

  task automatic test_reset_midflight();
    int k;
    clear_q();
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, rnd_op(), rnd_op(), 5'(20 + i));
      step();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    step();
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid: got wb_valid=%b busy=%b req_ready=%b want 0 0 1", bus.wb_valid, bus.busy, bus.req_ready);
    end
    step();
    step();
    rst_n = 1'b1;
    clear_q();
    step();
    drive(1'b1, 1'b1, 32'h40A00000, 32'h40000000, 5'd9);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    k = 0;
    while (obs_q.size() < 1 && k < 20) begin step(); k++; end
    repeat (8) step();
    n_chk++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL rst_after_count: got %0d want 1", obs_q.size()); end
    n_chk++; if (obs_q.size() < 1 || obs_q[0] !== {5'd9, 32'h40400000}) begin
      n_fail++; $display("FAIL rst_after_data: got %h want %h", (obs_q.size() > 0) ? obs_q[0] : 37'd0, {5'd9, 32'h40400000});
    end
    n_chk++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL rst_after_err: got %b want 0", bus.err_spurious); end
  endtask

  task automatic test_spurious();
    int bad;
    clear_q();
    force_ready = 1'b1;
    step();
    force_ready = 1'b0;
    n_chk++; if (bus.err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_set: got %b want 1", bus.err_spurious); end
    n_chk++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL spur_no_push: got wb_valid=%b busy=%b want 0 0", bus.wb_valid, bus.busy);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.err_spurious !== 1'b1 || bus.wb_valid !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL spur_sticky: %0d bad cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sub();
    test_full_credit();
    test_streaming();
    test_back_to_back_backpressure();
    test_reset_midflight();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
